// File: rtl/maze_solver_param.sv
// maze_solver_param: N x N wavefront BFS maze solver that streams the shortest START->END path.
module maze_solver_param #(
    parameter int N = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic [2*N-1:0]          row_i,
    output logic [1:0]              action_o,
    output logic [2*$clog2(N)-1:0]  coord_o,
    output logic                    done_o,
    output logic                    fail_o,
    output logic [2*$clog2(N):0]    path_len_o
);
    localparam int LOGN = $clog2(N);
    localparam int W = 2 * LOGN;
    localparam int C = N * N;

    function automatic logic [C-1:0] col_mask(input int col);
        logic [C-1:0] m;
        for (int i = 0; i < C; i++) m[i] = (i % N) == col;
        return m;
    endfunction

    localparam logic [C-1:0] FIRST_COL = col_mask(0);
    localparam logic [C-1:0] LAST_COL = col_mask(N - 1);

    typedef enum logic [1:0] {IDLE = 2'b00, INPUT = 2'b01, CAL = 2'b10, OUTPUT = 2'b11} state_t;

    state_t state_q, state_d;
    logic [LOGN:0] cnt_q, cnt_d;
    logic [W-1:0] start_q, start_d, end_q, end_d, coord_q, coord_d;
    logic [W:0] len_q, len_d;
    logic done_q, done_d, fail_q, fail_d;
    logic [C-1:0] wall_q, wall_d, front_q, front_d, seen_q, seen_d;
    logic [C-1:0][1:0] par_q, par_d;
    logic [C-1:0] fu, fd, fl, fr, adj, grow;
    logic [C-1:0][1:0] dir;
    logic [W-1:0] cw_start, cw_end, step;

    // Bit i of each vector says the cell on that side of cell i is frontier; no wrap across rows.
    assign fu = front_q << N;
    assign fd = front_q >> N;
    assign fl = (front_q << 1) & ~FIRST_COL;
    assign fr = (front_q >> 1) & ~LAST_COL;
    assign adj = fu | fd | fl | fr;
    assign grow = adj & ~wall_q & ~seen_q & ~front_q;
    assign cw_start = row_i[2*N-1 -: W];
    assign cw_end = row_i[2*N-1-W -: W];
    assign step = par_q[coord_q] == 2'd0 ? coord_q - W'(N) :
                  par_q[coord_q] == 2'd1 ? coord_q + W'(N) :
                  par_q[coord_q] == 2'd2 ? coord_q - W'(1) : coord_q + W'(1);

    always_comb begin
        for (int i = 0; i < C; i++) dir[i] = fu[i] ? 2'd0 : fd[i] ? 2'd1 : fl[i] ? 2'd2 : 2'd3;
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        start_d = start_q;
        end_d = end_q;
        coord_d = coord_q;
        len_d = len_q;
        done_d = done_q;
        fail_d = fail_q;
        wall_d = wall_q;
        front_d = front_q;
        seen_d = seen_q;
        par_d = par_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = INPUT;
                cnt_d = '0;
                done_d = 1'b0;
                fail_d = 1'b0;
                len_d = '0;
            end
            INPUT: begin
                cnt_d = cnt_q + 1'b1;
                front_d = '0;
                seen_d = '0;
                par_d = '0;
                if (cnt_q != (LOGN+1)'(N)) begin
                    for (int i = 0; i < C; i++)
                        if (cnt_q == (LOGN+1)'(i / N)) wall_d[i] = |row_i[2*N-1-2*(i%N) -: 2];
                end else begin
                    start_d = cw_start;
                    end_d = cw_end;
                    if (wall_q[cw_start] || wall_q[cw_end]) begin
                        state_d = IDLE;
                        fail_d = 1'b1;
                    end else if (cw_start == cw_end) begin
                        state_d = OUTPUT;
                        coord_d = cw_start;
                    end else begin
                        state_d = CAL;
                        front_d[cw_end] = 1'b1;
                    end
                end
            end
            CAL: begin
                seen_d = seen_q | front_q;
                front_d = grow;
                for (int i = 0; i < C; i++) if (grow[i]) par_d[i] = dir[i];
                if (adj[start_q]) begin
                    par_d[start_q] = dir[start_q];
                    state_d = OUTPUT;
                    coord_d = start_q;
                end else if (grow == '0) begin
                    state_d = IDLE;
                    fail_d = 1'b1;
                end
            end
            OUTPUT: begin
                len_d = len_q + (W+1)'(1);
                if (coord_q == end_q) begin
                    state_d = IDLE;
                    done_d = 1'b1;
                end else begin
                    coord_d = step;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Map, BFS and coordinate storage are rebuilt every INPUT phase, so only control state is reset.
    always_ff @(posedge clk) begin
        wall_q <= wall_d;
        front_q <= front_d;
        seen_q <= seen_d;
        par_q <= par_d;
        start_q <= start_d;
        end_q <= end_d;
        cnt_q <= cnt_d;
        if (reset) begin
            state_q <= IDLE;
            coord_q <= '0;
            len_q <= '0;
            done_q <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            state_q <= state_d;
            coord_q <= coord_d;
            len_q <= len_d;
            done_q <= done_d;
            fail_q <= fail_d;
        end
    end

    assign action_o = state_q;
    assign coord_o = coord_q;
    assign done_o = done_q;
    assign fail_o = fail_q;
    assign path_len_o = len_q;
endmodule

// File: tb/tb_maze_solver_param.sv
// tb_maze_solver_param: directed scenarios on N=8 and N=16 solvers with a coordinate scoreboard.
module tb_maze_solver_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start_i, sel;
    logic [31:0] row_w;
    logic [1:0] act8, act16;
    logic [5:0] coord8;
    logic [7:0] coord16;
    logic done8, done16, fail8, fail16;
    logic [6:0] len8;
    logic [8:0] len16;
    logic [1:0] act;
    logic [31:0] coord, len;
    logic done, fail;

    maze_solver_param #(.N(8)) dut8 (
        .clk(clk), .reset(reset), .start_i(start_i & ~sel), .row_i(row_w[15:0]),
        .action_o(act8), .coord_o(coord8), .done_o(done8), .fail_o(fail8), .path_len_o(len8)
    );

    maze_solver_param #(.N(16)) dut16 (
        .clk(clk), .reset(reset), .start_i(start_i & sel), .row_i(row_w),
        .action_o(act16), .coord_o(coord16), .done_o(done16), .fail_o(fail16), .path_len_o(len16)
    );

    assign act = sel ? act16 : act8;
    assign coord = sel ? 32'(coord16) : 32'(coord8);
    assign len = sel ? 32'(len16) : 32'(len8);
    assign done = sel ? done16 : done8;
    assign fail = sel ? fail16 : fail8;

    int tests = 0;
    int fails = 0;
    logic [31:0] map [16];
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word(input int n, input int sr, input int sc, input int er, input int ec);
        return n == 8 ? {16'h0, sr[2:0], sc[2:0], er[2:0], ec[2:0], 4'h0}
                      : {sr[3:0], sc[3:0], er[3:0], ec[3:0], 16'h0};
    endfunction

    task automatic fill_map(input logic [31:0] v);
        for (int r = 0; r < 16; r++) map[r] = v;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_act"}, 32'(act), 0);
        check({tag, "_coord"}, coord, 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_fail"}, 32'(fail), 0);
        check({tag, "_len"}, len, 0);
    endtask

    task automatic load(input int n, input logic [31:0] w);
        start_i = 1'b1;
        row_w = '0;
        step();
        start_i = 1'b0;
        check("start_act", 32'(act), 1);
        check("start_done", 32'(done), 0);
        check("start_fail", 32'(fail), 0);
        check("start_len", len, 0);
        for (int r = 0; r < n; r++) begin
            row_w = map[r];
            step();
            if (r < n - 1) check("load_act", 32'(act), 1);
        end
        row_w = w;
        check("word_act", 32'(act), 1);
        step();
        row_w = '0;
    endtask

    task automatic finish(input string name, input int exp_cal, input logic exp_fail, input int exp_len);
        int cal;
        int nout;
        int nexp;
        logic [31:0] e;
        cal = 0;
        nout = 0;
        nexp = exp_q.size();
        while (act == 2'b10 && cal < 300) begin
            cal++;
            step();
        end
        check({name, "_cal_cycles"}, cal, exp_cal);
        while (act == 2'b11 && nout < 300) begin
            e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hFFFF_FFFF;
            check({name, "_coord"}, coord, e);
            nout++;
            step();
        end
        check({name, "_out_cycles"}, nout, nexp);
        check({name, "_end_act"}, 32'(act), 0);
        check({name, "_done"}, 32'(done), 32'(!exp_fail));
        check({name, "_fail"}, 32'(fail), 32'(exp_fail));
        check({name, "_len"}, len, exp_len);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start_i = 1'b0;
        sel = 1'b0;
        row_w = '0;
        repeat (3) step();
        check_idle("reset");
        reset = 1'b0;
        step();
        check_idle("idle");

        fill_map('0);
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        load(8, word(8, 0, 0, 0, 3));
        finish("corridor", 3, 1'b0, 4);

        exp_q.push_back(0); exp_q.push_back(8); exp_q.push_back(9);
        load(8, word(8, 0, 0, 1, 1));
        finish("tiebreak", 2, 1'b0, 3);

        fill_map(32'h0000_0400);
        load(8, word(8, 0, 0, 0, 7));
        finish("nopath", 12, 1'b1, 0);

        fill_map('0);
        exp_q.push_back(27);
        load(8, word(8, 3, 3, 3, 3));
        finish("same", 0, 1'b0, 1);

        map[0] = 32'h0000_4000;
        load(8, word(8, 0, 0, 0, 3));
        finish("wallstart", 0, 1'b1, 0);

        fill_map('0);
        load(8, word(8, 0, 0, 0, 3));
        check("precal_act", 32'(act), 2);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle("midreset");
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        load(8, word(8, 0, 0, 0, 3));
        finish("after_reset", 3, 1'b0, 4);

        sel = 1'b1;
        step();
        check_idle("n16_idle");
        for (int r = 0; r < 16; r++) exp_q.push_back(r * 16);
        for (int c = 1; c < 16; c++) exp_q.push_back(240 + c);
        load(16, word(16, 0, 0, 15, 15));
        finish("n16", 30, 1'b0, 31);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
